// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one stop bit.
// Latency: start bit appears on tx_o the cycle after the accept edge; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: requests are accepted only in IDLE (including the tx_done_o cycle); requests while busy are dropped.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       tx_busy_o,
   output logic       tx_done_o
);

   // The timer only needs to reach CLKS_PER_BIT-1; at one cycle per bit it stays at zero.
   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q,   idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q,   par_d;
   logic          tx_q,    tx_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   logic          bit_end;

   // Last cycle of the current bit slot.
   assign bit_end = (timer_q == BIT_LAST);

   // Next-state and registered-output logic; tx_d is only changed at bit boundaries.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            timer_d = '0;
            idx_d   = '0;
            if (tx_start_i) begin
               // Byte and its parity are captured once; data_i is ignored afterwards.
               state_d = S_START;
               shift_d = data_i;
               par_d   = (^data_i) ^ PARITY_ODD;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               timer_d = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               if (idx_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               timer_d = '0;
               tx_d    = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               // First IDLE cycle carries the completion pulse and drops busy.
               state_d = S_IDLE;
               timer_d = '0;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame and wins over a request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_o      = tx_q;
   assign tx_busy_o = busy_q;
   assign tx_done_o = done_q;

endmodule
